// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : calc_pkg
//  Description : Shared constants and types for the calculator datapath.
//                It covers the operand width, the BCD digit count, the BCD
//                adjust threshold and the converter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int WIDTH      = 8;
    localparam int BCD_DIGITS = 3;

    // A nibble at or above this value overflows past 9 when it is doubled.
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/bcd_nibble_adj.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_nibble_adj
//  Description : Combinational double-dabble correction for one BCD digit.
//                It adds 3 when the digit is 5 or more, so the next left
//                shift carries correctly into the next decimal digit.
//  Ports       : i_nibble  [3:0]  BCD digit before the shift
//                o_nibble  [3:0]  corrected digit
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_nibble_adj
    import calc_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [3:0] o_nibble
);

    assign o_nibble = (i_nibble >= BCD_ADJ_THRESH) ? (i_nibble + 4'd3) : i_nibble;

endmodule : bcd_nibble_adj
`default_nettype wire

// File: rtl/sum_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : sum_to_bcd
//  Description : Sequential binary-to-BCD converter for the adder result.
//                On start it captures the sign and magnitude of the
//                add/subtract result. It then converts the magnitude with
//                double dabble, one bit per clock, and publishes the BCD
//                digits with a one-cycle valid pulse.
//  Ports       : CLK      clock
//                RST_N    synchronous reset, active low
//                i_start  start request, accepted only while idle
//                i_value  adder result {carry, sum}
//                i_sub    1 = subtract path, 0 = add path
//                o_busy   conversion in progress
//                o_valid  one-cycle pulse with new o_bcd / o_sign
//                o_sign   1 = negative result
//                o_bcd    {hundreds, tens, ones}
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_to_bcd
    import calc_pkg::*;
#(
    parameter int WIDTH  = calc_pkg::WIDTH,
    parameter int DIGITS = calc_pkg::BCD_DIGITS
)(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  i_start,
    input  logic [WIDTH:0]        i_value,
    input  logic                  i_sub,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic                  o_sign,
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int                  c_CNT_W    = $clog2(WIDTH + 2);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [WIDTH:0]      c_MAG_ONE  = (WIDTH+1)'(1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [WIDTH:0]            r_mag;
    logic [4*DIGITS-1:0]       r_bcd;
    logic [c_CNT_W-1:0]        r_cnt;
    logic                      r_sign;
    logic                      r_valid;
    logic                      r_sign_out;
    logic [4*DIGITS-1:0]       r_bcd_out;

    logic [WIDTH-1:0]          w_low;
    logic [WIDTH:0]            w_mag_cap;
    logic                      w_sign_cap;
    logic [4*DIGITS-1:0]       w_bcd_adj;
    logic [4*DIGITS+WIDTH:0]   w_shift;

    // Sign and magnitude of the incoming result.
    // A subtract without carry out is a borrow, so the low bits hold the
    // two's complement of the negative result. That magnitude needs the
    // extra bit, because a low byte of 0 means -2^WIDTH.
    assign w_low = i_value[WIDTH-1:0];

    always_comb begin
        w_sign_cap = 1'b0;
        w_mag_cap  = i_value;
        if (i_sub) begin
            if (i_value[WIDTH]) begin
                w_mag_cap = {1'b0, w_low};
            end else begin
                w_sign_cap = 1'b1;
                w_mag_cap  = {1'b0, ~w_low} + c_MAG_ONE;
            end
        end
    end

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_adj
            bcd_nibble_adj u_adj (
                .i_nibble (r_bcd[4*g +: 4]),
                .o_nibble (w_bcd_adj[4*g +: 4])
            );
        end
    endgenerate

    // Corrected digits and remaining magnitude move left as one register.
    assign w_shift = {w_bcd_adj, r_mag} << 1;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_next = SHIFT;
            SHIFT:   if (r_cnt == c_CNT_LAST) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_mag      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_sign     <= 1'b0;
            r_valid    <= 1'b0;
            r_sign_out <= 1'b0;
            r_bcd_out  <= '0;
        end else begin
            r_state <= w_state_next;
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_sign <= w_sign_cap;
                        r_mag  <= w_mag_cap;
                        r_bcd  <= '0;
                        r_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    r_bcd <= w_shift[4*DIGITS+WIDTH:WIDTH+1];
                    r_mag <= w_shift[WIDTH:0];
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
                DONE: begin
                    r_bcd_out  <= r_bcd;
                    r_sign_out <= r_sign;
                    r_valid    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy  = (r_state != IDLE);
    assign o_valid = r_valid;
    assign o_sign  = r_sign_out;
    assign o_bcd   = r_bcd_out;

endmodule : sum_to_bcd
`default_nettype wire

// File: tb/tb_sum_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_to_bcd
//  Description : Self-checking bench for sum_to_bcd. An arithmetic model
//                predicts busy, valid, digits and sign on every cycle.
//                Directed vectors also check literal expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_to_bcd;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic                CLK     = 1'b0;
    logic                RST_N   = 1'b0;
    logic                i_start = 1'b0;
    logic                i_sub   = 1'b0;
    logic [WIDTH:0]      i_value = '0;
    logic                o_busy;
    logic                o_valid;
    logic                o_sign;
    logic [4*DIGITS-1:0] o_bcd;

    int n_total = 0;
    int n_pass  = 0;

    sum_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_start (i_start),
        .i_value (i_value),
        .i_sub   (i_sub),
        .o_busy  (o_busy),
        .o_valid (o_valid),
        .o_sign  (o_sign),
        .o_bcd   (o_bcd)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic int mag_of(input logic [WIDTH:0] v, input logic sub);
        int lo;
        lo = int'(v) % (2**WIDTH);
        if (!sub)          return int'(v);
        else if (v[WIDTH]) return lo;
        else               return (2**WIDTH) - lo;
    endfunction

    function automatic logic [11:0] to_bcd(input int m);
        return 12'(((m / 100) << 8) | (((m / 10) % 10) << 4) | (m % 10));
    endfunction

    int          m_left  = 0;
    logic        m_valid = 1'b0;
    logic        m_sign  = 1'b0;
    logic [11:0] m_bcd   = '0;
    logic        p_sign  = 1'b0;
    logic [11:0] p_bcd   = '0;

    always @(posedge CLK) begin
        if (!RST_N) begin
            m_left  = 0;
            m_valid = 1'b0;
            m_sign  = 1'b0;
            m_bcd   = '0;
        end else begin
            m_valid = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1'b1;
                    m_bcd   = p_bcd;
                    m_sign  = p_sign;
                end
            end else if (i_start) begin
                p_bcd  = to_bcd(mag_of(i_value, i_sub));
                p_sign = i_sub && !i_value[WIDTH];
                m_left = WIDTH + 2;
            end
        end
    end

    always @(negedge CLK) begin
        chk("busy",  32'(o_busy),  32'(m_left > 0));
        chk("valid", 32'(o_valid), 32'(m_valid));
        chk("bcd",   32'(o_bcd),   32'(m_bcd));
        chk("sign",  32'(o_sign),  32'(m_sign));
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (o_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("valid_seen", 32'(ok), 32'd1);
    endtask

    task automatic conv(input logic [WIDTH:0] v, input logic sub,
                        input logic [11:0] exp_bcd, input logic exp_sign, input string name);
        bit ok;
        @(negedge CLK);
        i_value = v;
        i_sub   = sub;
        i_start = 1'b1;
        @(negedge CLK);
        i_start = 1'b0;
        wait_valid(ok);
        if (ok) begin
            chk({name, "_bcd"},  32'(o_bcd),  32'(exp_bcd));
            chk({name, "_sign"}, 32'(o_sign), 32'(exp_sign));
        end
    endtask

    initial begin
        bit ok;
        int nv;

        repeat (3) @(negedge CLK);
        chk("rst_busy",  32'(o_busy),  32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_bcd",   32'(o_bcd),   32'd0);
        RST_N = 1'b1;

        conv(9'h1FE, 1'b0, 12'h510, 1'b0, "add_max");
        conv(9'h1C7, 1'b0, 12'h455, 1'b0, "add_455");
        conv(9'h191, 1'b1, 12'h145, 1'b0, "sub_pos");
        conv(9'h0F6, 1'b1, 12'h010, 1'b1, "sub_neg");
        conv(9'h100, 1'b1, 12'h000, 1'b0, "sub_zero");
        conv(9'h000, 1'b1, 12'h256, 1'b1, "sub_m256");
        conv(9'h1FF, 1'b1, 12'h255, 1'b0, "sub_255");

        // i_start held and inputs toggling while busy
        @(negedge CLK);
        i_value = 9'h1C7; i_sub = 1'b0; i_start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            i_value = 9'($urandom);
            i_sub   = 1'($urandom);
        end
        @(negedge CLK);
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_bcd",   32'(o_bcd),   32'h455);
        chk("hold_sign",  32'(o_sign),  32'd0);
        i_start = 1'b0;
        nv = 0;
        repeat (5) begin
            @(negedge CLK);
            if (o_valid === 1'b1) nv++;
        end
        chk("hold_extra_valid", 32'(nv), 32'd0);

        // i_start through the valid cycle starts the next conversion
        @(negedge CLK);
        i_value = 9'h07B; i_sub = 1'b0; i_start = 1'b1;
        @(negedge CLK);
        i_value = 9'h191; i_sub = 1'b1;
        wait_valid(ok);
        chk("b2b_first", 32'(o_bcd), 32'h123);
        @(negedge CLK);
        chk("b2b_rebusy", 32'(o_busy), 32'd1);
        i_start = 1'b0;
        wait_valid(ok);
        chk("b2b_second", 32'(o_bcd), 32'h145);

        // reset in the middle of a conversion
        @(negedge CLK);
        i_value = 9'h1FE; i_sub = 1'b0; i_start = 1'b1;
        @(negedge CLK);
        i_start = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("mid_rst_busy",  32'(o_busy),  32'd0);
        chk("mid_rst_bcd",   32'(o_bcd),   32'd0);
        chk("mid_rst_sign",  32'(o_sign),  32'd0);
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        RST_N = 1'b1;
        nv = 0;
        repeat (14) begin
            @(negedge CLK);
            if (o_valid === 1'b1) nv++;
        end
        chk("mid_rst_no_valid", 32'(nv), 32'd0);
        conv(9'h07B, 1'b0, 12'h123, 1'b0, "after_rst");

        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sum_to_bcd
`default_nettype wire
